wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 124 ++++++++++++
 tb/tb_wb_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: selects the memory or ALU result and writes it to a 64-bit
// register-file port as three consecutive beats, pulsing retired on completion.
module wb_stage #(
   parameter int unsigned DATA_W = 192,
   parameter int unsigned BEAT_W = 64,
   parameter int unsigned REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        mem,
   input  logic              wb_en,
   input  logic [REG_AW-1:0] rd,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] mem_data,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_addr,
   output logic [1:0]        rf_beat,
   output logic [BEAT_W-1:0] rf_wdata,
   output logic              busy,
   output logic              retired
);

   localparam logic [1:0] LAST_BEAT = 2'd2;
   localparam logic [2:0] MEM_LOAD  = 3'b000;

   typedef enum logic {IDLE, WRITE} state_t;

   state_t              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [REG_AW-1:0]   rd_q, rd_d;
   logic                accept, is_load, suppress;

   logic                write_d;
   logic                in_ready_d, rf_we_d, busy_d, retired_d;
   logic [REG_AW-1:0]   rf_addr_d;
   logic [1:0]          rf_beat_d;
   logic [BEAT_W-1:0]   rf_wdata_d, beat_sel;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state, beat counter and captured operands
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      rd_d     = rd_q;
      accept   = 1'b0;
      is_load  = mem[3] && (mem[2:0] == MEM_LOAD);
      suppress = !wb_en || (mem[3] && (mem[2:0] != MEM_LOAD));
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               accept = 1'b1;
               data_d = is_load ? mem_data : alu_result;
               rd_d   = rd;
               if (!suppress) begin
                  state_d = WRITE;
                  cnt_d   = 2'd0;
               end
            end
         end
         WRITE: begin
            if (cnt_q == LAST_BEAT) begin
               state_d = IDLE;
               cnt_d   = 2'd0;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output values for the next cycle, so every output comes straight from a flop
   always_comb begin
      write_d = (state_d == WRITE);
      case (cnt_d)
         2'd0:    beat_sel = data_d[BEAT_W-1:0];
         2'd1:    beat_sel = data_d[2*BEAT_W-1 -: BEAT_W];
         default: beat_sel = data_d[3*BEAT_W-1 -: BEAT_W];
      endcase
      in_ready_d = !write_d;
      busy_d     = write_d;
      rf_we_d    = write_d;
      rf_addr_d  = write_d ? rd_d : '0;
      rf_beat_d  = write_d ? cnt_d : 2'd0;
      rf_wdata_d = write_d ? beat_sel : '0;
      retired_d  = (write_d && (cnt_d == LAST_BEAT)) || (accept && suppress);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q    <= 2'd0;
         data_q   <= '0;
         rd_q     <= '0;
         in_ready <= 1'b1;
         busy     <= 1'b0;
         rf_we    <= 1'b0;
         rf_addr  <= '0;
         rf_beat  <= 2'd0;
         rf_wdata <= '0;
         retired  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         rd_q     <= rd_d;
         in_ready <= in_ready_d;
         busy     <= busy_d;
         rf_we    <= rf_we_d;
         rf_addr  <= rf_addr_d;
         rf_beat  <= rf_beat_d;
         rf_wdata <= rf_wdata_d;
         retired  <= retired_d;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed and random instructions compared per cycle
// against a transaction-level queue of expected register-file activity.
module tb_wb_stage;

   localparam int unsigned DATA_W = 192;
   localparam int unsigned BEAT_W = 64;
   localparam int unsigned REG_AW = 5;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        mem;
   logic              wb_en;
   logic [REG_AW-1:0] rd;
   logic [DATA_W-1:0] alu_result;
   logic [DATA_W-1:0] mem_data;
   logic              rf_we;
   logic [REG_AW-1:0] rf_addr;
   logic [1:0]        rf_beat;
   logic [BEAT_W-1:0] rf_wdata;
   logic              busy;
   logic              retired;

   wb_stage #(.DATA_W(DATA_W), .BEAT_W(BEAT_W), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .mem(mem), .wb_en(wb_en), .rd(rd), .alu_result(alu_result),
      .mem_data(mem_data), .rf_we(rf_we), .rf_addr(rf_addr),
      .rf_beat(rf_beat), .rf_wdata(rf_wdata), .busy(busy), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic              we;
      logic [REG_AW-1:0] addr;
      logic [1:0]        beat;
      logic [BEAT_W-1:0] data;
      logic              ret;
      logic              bsy;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_we, n_nrdy, n_ret;

   task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand192();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // One cycle: check what the DUT shows now, drive inputs, advance the model.
   // Entered and left at a falling edge.
   task automatic step(input logic v, input logic [3:0] m, input logic w,
                       input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] d);
      exp_t e;
      logic acc, sup;
      logic [DATA_W-1:0] val;
      e = '0;
      if (q.size() > 0) e = q[0];
      chk("rf_we",    DATA_W'(rf_we),    DATA_W'(e.we));
      chk("rf_addr",  DATA_W'(rf_addr),  DATA_W'(e.addr));
      chk("rf_beat",  DATA_W'(rf_beat),  DATA_W'(e.beat));
      chk("rf_wdata", DATA_W'(rf_wdata), DATA_W'(e.data));
      chk("retired",  DATA_W'(retired),  DATA_W'(e.ret));
      chk("busy",     DATA_W'(busy),     DATA_W'(e.bsy));
      chk("in_ready", DATA_W'(in_ready), DATA_W'(!e.bsy));
      n_we   += int'(rf_we);
      n_nrdy += int'(!in_ready);
      n_ret  += int'(retired);
      in_valid = v; mem = m; wb_en = w; rd = r; alu_result = a; mem_data = d;
      acc = v && !e.bsy;
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
         sup = !w || (m[3] && m[2:0] != 3'b000);
         val = (m == 4'b1000) ? d : a;
         if (sup) begin
            e = '0; e.ret = 1'b1;
            q.push_back(e);
         end else begin
            for (int i = 0; i < 3; i++) begin
               e.we   = 1'b1;
               e.addr = r;
               e.beat = 2'(i);
               e.data = BEAT_W'(val >> (BEAT_W * i));
               e.ret  = (i == 2);
               e.bsy  = 1'b1;
               q.push_back(e);
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 4'($urandom), 1'($urandom), REG_AW'($urandom), rand192(), rand192());
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rf_we"},    DATA_W'(rf_we),    '0);
      chk({tag, "_retired"},  DATA_W'(retired),  '0);
      chk({tag, "_busy"},     DATA_W'(busy),     '0);
      chk({tag, "_in_ready"}, DATA_W'(in_ready), DATA_W'(1));
      chk({tag, "_rf_beat"},  DATA_W'(rf_beat),  '0);
      chk({tag, "_rf_wdata"}, DATA_W'(rf_wdata), '0);
   endtask

   logic [DATA_W-1:0] load_d;

   initial begin
      rst = 1'b0; in_valid = 1'b0; mem = '0; wb_en = 1'b0; rd = '0;
      alu_result = '0; mem_data = '0;
      n_we = 0; n_nrdy = 0; n_ret = 0;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b1;

      // Load to r7
      load_d = {64'hAAAA_3333_CCCC_0003, 64'hAAAA_2222_BBBB_0002, 64'hAAAA_1111_DDDD_0001};
      step(1'b1, 4'b1000, 1'b1, 5'd7, rand192(), load_d);
      idle(4);
      // ALU result to r3 with memory data all ones
      step(1'b1, 4'b0000, 1'b1, 5'd3, 192'h1, '1);
      idle(4);
      // Store, then reserved memory op: no write, single retired pulse
      step(1'b1, 4'b1001, 1'b1, 5'd9, rand192(), rand192());
      idle(2);
      step(1'b1, 4'b1010, 1'b1, 5'd11, rand192(), rand192());
      idle(2);
      // Back-to-back suppressed instructions
      for (int i = 0; i < 4; i++)
         step(1'b1, 4'b0000, 1'b0, REG_AW'(i), rand192(), rand192());
      idle(2);

      // Continuous in_valid with three writing instructions
      n_we = 0; n_nrdy = 0; n_ret = 0;
      for (int i = 0; i < 12; i++)
         step(1'b1, (i % 2 == 0) ? 4'b1000 : 4'b0000, 1'b1, REG_AW'($urandom), rand192(), rand192());
      step(1'b0, 4'b0000, 1'b0, '0, '0, '0);
      chk("stream_we_beats", DATA_W'(n_we), DATA_W'(9));
      chk("stream_not_ready", DATA_W'(n_nrdy), DATA_W'(9));
      chk("stream_retired", DATA_W'(n_ret), DATA_W'(3));

      // Reset during beat 1 aborts the write
      step(1'b1, 4'b1000, 1'b1, 5'd21, rand192(), rand192());
      idle(1);
      chk("pre_abort_beat", DATA_W'(rf_beat), DATA_W'(1));
      rst = 1'b0;
      #1;
      check_reset_outputs("abort");
      q.delete();
      in_valid = 1'b0;
      @(negedge clk);
      check_reset_outputs("abort_hold");
      rst = 1'b1;
      step(1'b1, 4'b1000, 1'b1, 5'd22, rand192(), rand192());
      idle(4);

      // Random traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 3) != 0),
              REG_AW'($urandom), rand192(), rand192());
      idle(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
